// File: rtl/rtc_time_core.sv
// rtc_time_core: 1 Hz prescaler, HH:MM:SS timekeeping and BCD display outputs.
// It also provides 12/24-hour display, hold-to-edit set mode, and an optional alarm.
// Optional alarm: define RTC_ALARM_EN to add alarm hour/minute fields 3 and 4.
module rtc_time_core #(
    parameter int CLK_HZ = 12_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr,
    input  logic       i_sel_inc,
    input  logic       i_sel_dec,
    input  logic       i_val_inc,
    input  logic       i_val_dec,
    input  logic       i_mode_24h,
    input  logic       i_alarm_arm,
    output logic [7:0] o_hh,
    output logic [7:0] o_mm,
    output logic [7:0] o_ss,
    output logic       o_pm,
    output logic       o_edit,
    output logic [2:0] o_sel,
    output logic       o_tick,
    output logic       o_alarm
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
`ifdef RTC_ALARM_EN
    localparam logic [2:0] SEL_LAST = 3'd4;
`else
    localparam logic [2:0] SEL_LAST = 3'd2;
`endif

    logic [PW-1:0] presc, presc_n;
    logic [4:0]    hour, hour_n, disp_hour;
    logic [5:0]    min, min_n, sec, sec_n;
    logic          edit, edit_n, tick_n, pm_n, alarm_n;
    logic [2:0]    sel, sel_n;
    logic [5:0]    fld_cur, fld_max, fld_new;
`ifdef RTC_ALARM_EN
    logic [4:0]    al_hour, al_hour_n;
    logic [5:0]    al_min, al_min_n;
`else
    logic          unused_arm;
    assign unused_arm = i_alarm_arm;
`endif

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] vmax,
                                             input logic up);
        if (up) return (v == vmax) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? vmax : v - 6'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // Next-state: mode toggle, field editing, or prescaler/time advance;
    // outputs are registered from these next values so they match the state.
    always_comb begin
        presc_n = presc;
        hour_n  = hour;
        min_n   = min;
        sec_n   = sec;
        edit_n  = edit;
        sel_n   = sel;
        tick_n  = 1'b0;
        fld_cur = 6'd0;
        fld_max = 6'd59;
`ifdef RTC_ALARM_EN
        al_hour_n = al_hour;
        al_min_n  = al_min;
`endif
        case (sel)
            3'd0: begin fld_cur = {1'b0, hour}; fld_max = 6'd23; end
            3'd1: fld_cur = min;
            3'd2: fld_cur = sec;
`ifdef RTC_ALARM_EN
            3'd3: begin fld_cur = {1'b0, al_hour}; fld_max = 6'd23; end
            3'd4: fld_cur = al_min;
`endif
            default: ;
        endcase
        fld_new = wrap_step(fld_cur, fld_max, i_val_inc);

        if (i_wr) begin
            // Mode toggle pre-empts everything else this cycle, including a tick.
            edit_n  = ~edit;
            presc_n = '0;
            if (!edit) sel_n = 3'd0;
        end else if (edit) begin
            if (i_val_inc ^ i_val_dec) begin
                case (sel)
                    3'd0: hour_n = fld_new[4:0];
                    3'd1: min_n  = fld_new;
                    3'd2: sec_n  = fld_new;
`ifdef RTC_ALARM_EN
                    3'd3: al_hour_n = fld_new[4:0];
                    3'd4: al_min_n  = fld_new;
`endif
                    default: ;
                endcase
            end
            if (i_sel_inc & ~i_sel_dec)
                sel_n = (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
            else if (i_sel_dec & ~i_sel_inc)
                sel_n = (sel == 3'd0) ? SEL_LAST : sel - 3'd1;
        end else if (presc == PRESC_MAX) begin
            presc_n = '0;
            tick_n  = 1'b1;
            if (sec == 6'd59) begin
                sec_n = 6'd0;
                if (min == 6'd59) begin
                    min_n  = 6'd0;
                    hour_n = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                end else begin
                    min_n = min + 6'd1;
                end
            end else begin
                sec_n = sec + 6'd1;
            end
        end else begin
            presc_n = presc + 1'b1;
        end

        if (i_mode_24h)          disp_hour = hour_n;
        else if (hour_n == 5'd0) disp_hour = 5'd12;
        else if (hour_n > 5'd12) disp_hour = hour_n - 5'd12;
        else                     disp_hour = hour_n;
        pm_n = ~i_mode_24h & (hour_n >= 5'd12);
`ifdef RTC_ALARM_EN
        alarm_n = ~edit_n & i_alarm_arm & (hour_n == al_hour_n) & (min_n == al_min_n);
`else
        alarm_n = 1'b0;
`endif
    end

    // State and registered display outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc   <= '0;
            hour    <= 5'd0;
            min     <= 6'd0;
            sec     <= 6'd0;
            edit    <= 1'b0;
            sel     <= 3'd0;
            o_hh    <= i_mode_24h ? 8'h00 : 8'h12;
            o_mm    <= 8'h00;
            o_ss    <= 8'h00;
            o_pm    <= 1'b0;
            o_edit  <= 1'b0;
            o_sel   <= 3'd0;
            o_tick  <= 1'b0;
            o_alarm <= 1'b0;
        end else begin
            presc   <= presc_n;
            hour    <= hour_n;
            min     <= min_n;
            sec     <= sec_n;
            edit    <= edit_n;
            sel     <= sel_n;
            o_hh    <= to_bcd({1'b0, disp_hour});
            o_mm    <= to_bcd(min_n);
            o_ss    <= to_bcd(sec_n);
            o_pm    <= pm_n;
            o_edit  <= edit_n;
            o_sel   <= sel_n;
            o_tick  <= tick_n;
            o_alarm <= alarm_n;
        end
    end

`ifdef RTC_ALARM_EN
    // Alarm set-point registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            al_hour <= 5'd0;
            al_min  <= 6'd0;
        end else begin
            al_hour <= al_hour_n;
            al_min  <= al_min_n;
        end
    end
`endif
endmodule

// File: tb/tb_rtc_time_core.sv
// Scoreboard bench for rtc_time_core: a seconds-of-day reference model pushes the
// expected outputs for every driven cycle, and a monitor pops and compares them.
module tb_rtc_time_core;
    localparam int CLK_HZ = 3;
`ifdef RTC_ALARM_EN
    localparam int NF = 5;
`else
    localparam int NF = 3;
`endif

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic       edit;
        logic [2:0] sel;
        logic       tick;
        logic       alarm;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1, wr = 1'b0, si = 1'b0, sd = 1'b0, vi = 1'b0, vd = 1'b0;
    logic m24 = 1'b1, arm = 1'b0;
    logic [7:0] hh, mm, ss;
    logic pm, edit, tick, alarm;
    logic [2:0] sel;

    rtc_time_core #(.CLK_HZ(CLK_HZ)) dut (
        .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_sel_inc(si), .i_sel_dec(sd),
        .i_val_inc(vi), .i_val_dec(vd), .i_mode_24h(m24), .i_alarm_arm(arm),
        .o_hh(hh), .o_mm(mm), .o_ss(ss), .o_pm(pm), .o_edit(edit), .o_sel(sel),
        .o_tick(tick), .o_alarm(alarm)
    );

    always #5 clk = ~clk;

    // Reference model state (time kept as seconds since midnight).
    int  t_tod = 0, t_presc = 0, t_sel = 0, t_ah = 0, t_am = 0;
    bit  t_edit = 0;
    bit  want_m24 = 1, want_arm = 0;
    out_t exp_q[$];
    int  checks = 0, passed = 0, cyc_n = 0;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic model(input bit r, w, s_i, s_d, v_i, v_d);
        out_t e;
        int h, m, s, d, h12;
        e = '0;
        if (r) begin
            t_tod = 0; t_presc = 0; t_edit = 0; t_sel = 0; t_ah = 0; t_am = 0;
        end else if (w) begin
            if (!t_edit) t_sel = 0;
            t_edit = !t_edit;
            t_presc = 0;
        end else if (t_edit) begin
            if (v_i != v_d) begin
                d = v_i ? 1 : -1;
                h = t_tod / 3600; m = (t_tod / 60) % 60; s = t_tod % 60;
                case (t_sel)
                    0: h = (h + d + 24) % 24;
                    1: m = (m + d + 60) % 60;
                    2: s = (s + d + 60) % 60;
                    3: t_ah = (t_ah + d + 24) % 24;
                    default: t_am = (t_am + d + 60) % 60;
                endcase
                t_tod = h * 3600 + m * 60 + s;
            end
            if (s_i != s_d) t_sel = (t_sel + (s_i ? 1 : -1) + NF) % NF;
        end else if (t_presc == CLK_HZ - 1) begin
            t_presc = 0;
            t_tod = (t_tod + 1) % 86400;
            e.tick = 1'b1;
        end else begin
            t_presc++;
        end
        h = t_tod / 3600; m = (t_tod / 60) % 60; s = t_tod % 60;
        h12 = (h % 12 == 0) ? 12 : h % 12;
        e.hh = bcd(want_m24 ? h : h12);
        e.mm = bcd(m);
        e.ss = bcd(s);
        e.pm = !want_m24 && h >= 12;
        e.edit = t_edit;
        e.sel = 3'(t_sel);
`ifdef RTC_ALARM_EN
        e.alarm = !t_edit && want_arm && h == t_ah && m == t_am;
`else
        e.alarm = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: drive at negedge, record expectation for the next posedge.
    task automatic cyc(input bit r, w, s_i, s_d, v_i, v_d);
        @(negedge clk);
        rst = r; wr = w; si = s_i; sd = s_d; vi = v_i; vd = v_d;
        m24 = want_m24; arm = want_arm;
        model(r, w, s_i, s_d, v_i, v_d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic rep_inc(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 1, 0);
    endtask

    // Monitor: outputs are valid every cycle, compare one entry per edge.
    always @(posedge clk) begin
        out_t got, want;
        #1;
        cyc_n++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = '{hh, mm, ss, pm, edit, sel, tick, alarm};
            checks++;
            if (got === want) passed++;
            else if (checks - passed <= 30)
                $display("FAIL outputs cycle %0d: got hh=%h mm=%h ss=%h pm=%b edit=%b sel=%0d tick=%b alarm=%b, expected hh=%h mm=%h ss=%h pm=%b edit=%b sel=%0d tick=%b alarm=%b",
                         cyc_n, got.hh, got.mm, got.ss, got.pm, got.edit, got.sel, got.tick, got.alarm,
                         want.hh, want.mm, want.ss, want.pm, want.edit, want.sel, want.tick, want.alarm);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset in 24h, then in 12h (o_hh must read 12), then back to 24h.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        want_m24 = 0;
        cyc(1, 0, 0, 0, 0, 0);
        want_m24 = 1;
        cyc(1, 0, 0, 0, 0, 0);
        idle(10 * CLK_HZ);

        // Edit: hour dec wraps to 23, minute inc x61 wraps to 01, strobes collide.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0);
        rep_inc(61);
        idle(8);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1, 0);
        idle(3 * CLK_HZ);

        // Preload 23:59:58 and cross midnight in 12h mode.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        want_m24 = 0;
        cyc(0, 1, 0, 0, 0, 0);
        idle(3 * CLK_HZ);
        want_m24 = 1;
        idle(2);

        // Reset while editing at 07:30:15.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        rep_inc(7);
        cyc(0, 0, 1, 0, 0, 0);
        rep_inc(30);
        cyc(0, 0, 1, 0, 0, 0);
        rep_inc(15);
        cyc(1, 0, 0, 0, 0, 0);
        idle(2 * CLK_HZ);

`ifdef RTC_ALARM_EN
        // Alarm at 00:01, run from 00:00:58, disarm mid-minute then re-arm.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        want_arm = 1;
        cyc(0, 1, 0, 0, 0, 0);
        idle(32 * CLK_HZ);
        want_arm = 0;
        idle(2);
        want_arm = 1;
        idle(32 * CLK_HZ);
`endif

        // Randomised strobes, mode flips, arm flips and occasional reset.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 49) == 0) want_m24 = !want_m24;
            if ($urandom_range(0, 29) == 0) want_arm = !want_arm;
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end

        idle(1);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
